// File: rtl/game_countdown_if.sv
// Control/status bundle between a game controller and the countdown timer.
interface game_countdown_if;
    logic       state;
    logic       pause;
    logic       sec_tick;
    logic       half_tick;
    logic       bonus;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       warning;
    logic       blink;
    logic       time_up;
    logic       timeout;

    // Controller side: drives game level and tick pulses, observes the timer.
    modport master (
        output state, pause, sec_tick, half_tick, bonus,
        input  sec_tens, sec_ones, running, warning, blink, time_up, timeout
    );

    // Timer side.
    modport slave (
        input  state, pause, sec_tick, half_tick, bonus,
        output sec_tens, sec_ones, running, warning, blink, time_up, timeout
    );
endinterface

// File: rtl/game_countdown.sv
// Game countdown timer: 0..99 s binary counter with BCD readout, pause,
// bonus time extension, low-time warning/blink and expiry signalling.
module game_countdown #(
    parameter int unsigned START_SEC = 60,
    parameter int unsigned WARN_SEC  = 10,
    parameter int unsigned BONUS_SEC = 5
) (
    input logic             clk,
    input logic             rst,
    game_countdown_if.slave bus
);
    localparam int unsigned CNT_W = 7;
    localparam int unsigned SUM_W = 8;
    localparam logic [CNT_W-1:0] START_V = CNT_W'(START_SEC);
    localparam logic [CNT_W-1:0] WARN_V  = CNT_W'(WARN_SEC);
    localparam logic [SUM_W-1:0] BONUS_V = SUM_W'(BONUS_SEC);
    localparam logic [SUM_W-1:0] MAX_V   = SUM_W'(99);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sum;
    logic             blink_q, blink_d;
    logic             time_up_q, time_up_d;
    logic             warn_c;

    // State, count and registered flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= S_IDLE;
            cnt_q     <= START_V;
            blink_q   <= 1'b0;
            time_up_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            cnt_q     <= cnt_d;
            blink_q   <= blink_d;
            time_up_q <= time_up_d;
        end
    end

    // Next state and count; bonus is added before the tick so a combined
    // pulse at cnt==1 never expires, and the result saturates at 99.
    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        sum   = SUM_W'(cnt_q);
        if (!bus.state) begin
            fsm_d = S_IDLE;
            cnt_d = START_V;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    cnt_d = START_V;
                    fsm_d = S_RUN;
                end
                S_RUN: begin
                    if (bus.pause) begin
                        fsm_d = S_PAUSE;
                    end else begin
                        if (bus.bonus)
                            sum = sum + BONUS_V;
                        if (bus.sec_tick && (sum != '0))
                            sum = sum - SUM_W'(1);
                        if (sum > MAX_V)
                            sum = MAX_V;
                        cnt_d = CNT_W'(sum);
                        if (sum == '0)
                            fsm_d = S_DONE;
                    end
                end
                S_PAUSE: begin
                    if (!bus.pause)
                        fsm_d = S_RUN;
                end
                S_DONE: begin
                    cnt_d = '0;
                end
                default: begin
                    fsm_d = S_IDLE;
                    cnt_d = START_V;
                end
            endcase
        end
    end

    // Status outputs, BCD decode and next values of the registered flags.
    always_comb begin
        warn_c       = ((fsm_q == S_RUN) || (fsm_q == S_PAUSE)) &&
                       (cnt_q <= WARN_V) && (cnt_q != '0);
        bus.sec_tens = 4'(cnt_q / CNT_W'(10));
        bus.sec_ones = 4'(cnt_q % CNT_W'(10));
        bus.running  = (fsm_q == S_RUN);
        bus.warning  = warn_c;
        bus.timeout  = (fsm_q == S_DONE);
        bus.blink    = blink_q;
        bus.time_up  = time_up_q;

        time_up_d = (fsm_d == S_DONE) && (fsm_q != S_DONE);
        blink_d   = 1'b0;
        if ((fsm_q == S_RUN) && warn_c)
            blink_d = blink_q ^ bus.half_tick;
        else if (fsm_q == S_PAUSE)
            blink_d = blink_q;
    end
endmodule

// File: tb/tb_game_countdown.sv
// Directed bench for game_countdown with default parameters (60/10/5).
module tb_game_countdown;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    game_countdown_if bus ();

    game_countdown #(.START_SEC(60), .WARN_SEC(10), .BONUS_SEC(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Compare one observed value against the expected one.
    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; sampling happens 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle with the given pulses asserted.
    task automatic pulse(input bit t, input bit b, input bit h);
        bus.sec_tick  = t;
        bus.bonus     = b;
        bus.half_tick = h;
        step();
        bus.sec_tick  = 1'b0;
        bus.bonus     = 1'b0;
        bus.half_tick = 1'b0;
    endtask

    function automatic int cnt_now();
        return int'(bus.sec_tens) * 10 + int'(bus.sec_ones);
    endfunction

    initial begin
        int exp_cnt;
        rst           = 1'b1;
        bus.state     = 1'b0;
        bus.pause     = 1'b0;
        bus.sec_tick  = 1'b0;
        bus.half_tick = 1'b0;
        bus.bonus     = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset values
        check("rst_tens",    int'(bus.sec_tens), 6);
        check("rst_ones",    int'(bus.sec_ones), 0);
        check("rst_running", int'(bus.running),  0);
        check("rst_warning", int'(bus.warning),  0);
        check("rst_timeout", int'(bus.timeout),  0);
        check("rst_time_up", int'(bus.time_up),  0);
        check("rst_blink",   int'(bus.blink),    0);

        // Start: a tick in the transition cycle is ignored
        bus.state = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        check("start_running", int'(bus.running), 1);
        check("start_cnt",     cnt_now(), 60);

        // Full countdown with warning/blink probes at 11 and 10
        for (int i = 1; i <= 60; i++) begin
            pulse(1'b1, 1'b0, 1'b0);
            exp_cnt = 60 - i;
            check("cd_cnt",  cnt_now(), exp_cnt);
            check("cd_warn", int'(bus.warning), (exp_cnt <= 10 && exp_cnt != 0) ? 1 : 0);
            check("cd_time_up", int'(bus.time_up), (exp_cnt == 0) ? 1 : 0);
            if (exp_cnt == 11) begin
                pulse(1'b0, 1'b0, 1'b1);
                check("blink_at11", int'(bus.blink),   0);
                check("warn_at11",  int'(bus.warning), 0);
            end
            if (exp_cnt == 10) begin
                for (int k = 0; k < 4; k++) begin
                    pulse(1'b0, 1'b0, 1'b1);
                    check("blink_at10", int'(bus.blink), (k % 2 == 0) ? 1 : 0);
                    check("warn_at10",  int'(bus.warning), 1);
                end
            end
        end
        check("done_timeout", int'(bus.timeout), 1);
        check("done_running", int'(bus.running), 0);
        check("done_warning", int'(bus.warning), 0);
        pulse(1'b1, 1'b1, 1'b0);
        check("done_time_up_once", int'(bus.time_up), 0);
        check("done_cnt_held",     cnt_now(), 0);
        check("done_timeout2",     int'(bus.timeout), 1);

        // Leave DONE via state==0, then restart
        bus.state = 1'b0;
        step();
        check("idle_cnt",     cnt_now(), 60);
        check("idle_timeout", int'(bus.timeout), 0);
        check("idle_running", int'(bus.running), 0);
        bus.state = 1'b1;
        step();
        check("rerun_running", int'(bus.running), 1);

        // Pause at 30: tick on the pause edge and during the pause are ignored
        for (int i = 0; i < 30; i++) pulse(1'b1, 1'b0, 1'b0);
        check("pre_pause_cnt", cnt_now(), 30);
        bus.pause = 1'b1;
        pulse(1'b1, 1'b1, 1'b0);
        check("pause_cnt",     cnt_now(), 30);
        check("pause_running", int'(bus.running), 0);
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0);
        check("paused_cnt", cnt_now(), 30);
        bus.pause = 1'b0;
        step();
        check("resume_running", int'(bus.running), 1);
        check("resume_cnt",     cnt_now(), 30);
        pulse(1'b1, 1'b0, 1'b0);
        check("resume_tick", cnt_now(), 29);

        // Bonus saturation: 29 + 5*15 -> 99, two ticks -> 97, bonus -> 99
        for (int i = 0; i < 15; i++) pulse(1'b0, 1'b1, 1'b0);
        check("bonus_sat1", cnt_now(), 99);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        check("cnt97", cnt_now(), 97);
        pulse(1'b0, 1'b1, 1'b0);
        check("bonus_sat2", cnt_now(), 99);
        pulse(1'b1, 1'b1, 1'b0);
        check("both_at99", cnt_now(), 99);

        // Down to 3, then combined bonus+tick -> 07
        for (int i = 0; i < 96; i++) pulse(1'b1, 1'b0, 1'b0);
        check("cnt3", cnt_now(), 3);
        pulse(1'b1, 1'b1, 1'b0);
        check("both_tens", int'(bus.sec_tens), 0);
        check("both_ones", int'(bus.sec_ones), 7);

        // Combined pulses at cnt==1 -> 5, no expiry
        for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0, 1'b0);
        check("cnt1", cnt_now(), 1);
        pulse(1'b1, 1'b1, 1'b0);
        check("at1_cnt",     cnt_now(), 5);
        check("at1_time_up", int'(bus.time_up), 0);
        check("at1_running", int'(bus.running), 1);

        // Reset mid-RUN at 20
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 1'b0);
        check("cnt20", cnt_now(), 20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstrun_cnt",     cnt_now(), 60);
        check("rstrun_running", int'(bus.running), 0);
        check("rstrun_time_up", int'(bus.time_up), 0);

        // Reset mid-DONE: no pulse, back to IDLE
        step();
        for (int i = 0; i < 60; i++) pulse(1'b1, 1'b0, 1'b0);
        check("done2_timeout", int'(bus.timeout), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstdone_cnt",     cnt_now(), 60);
        check("rstdone_timeout", int'(bus.timeout), 0);
        check("rstdone_time_up", int'(bus.time_up), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/game_countdown.md
GAME_COUNTDOWN -- requirements
Module: game_countdown

Interface
REQ-001 Parameter START_SEC, default 60, meaning the countdown load value in seconds; legal range 1..99.
REQ-002 Parameter WARN_SEC, default 10, meaning the warning threshold in seconds; legal range 0..99.
REQ-003 Parameter BONUS_SEC, default 5, meaning the seconds added per bonus pulse; legal range 0..99.
REQ-004 clk  input  1  meaning the system clock; all state changes on the rising edge.
REQ-005 rst  input  1  meaning synchronous, active-high reset.
REQ-006 state  input  1  meaning game level: 1 = game active, 0 = game idle/menu.
REQ-007 pause  input  1  meaning freeze level: 1 = countdown held.
REQ-008 sec_tick  input  1  meaning a single-cycle pulse, one per elapsed second.
REQ-009 half_tick  input  1  meaning a single-cycle pulse, one per elapsed half second.
REQ-010 bonus  input  1  meaning a single-cycle pulse requesting a BONUS_SEC time extension.
REQ-011 sec_tens  output  4  meaning the BCD tens digit of the remaining seconds.
REQ-012 sec_ones  output  4  meaning the BCD ones digit of the remaining seconds.
REQ-013 running  output  1  meaning the FSM is in RUN.
REQ-014 warning  output  1  meaning low time remains while RUN or PAUSE is active.
REQ-015 blink  output  1  meaning the display-flash phase.
REQ-016 time_up  output  1  meaning a single-cycle pulse on expiry.
REQ-017 timeout  output  1  meaning a level that holds while in DONE.

Function
REQ-018 The block SHALL hold the remaining time in a 7-bit binary register cnt (range 0..99), and sec_tens/sec_ones SHALL be a combinational BCD decode of cnt with zero cycles of latency.
REQ-019 The FSM SHALL have four states: IDLE, RUN, PAUSE, DONE.
REQ-020 Input priority on each edge SHALL be: rst, then state==0, then pause, then sec_tick/bonus.
REQ-021 In any state, state==0 SHALL cause next state IDLE with cnt=START_SEC.
REQ-022 In IDLE, cnt SHALL be START_SEC, and state==1 SHALL cause a move to RUN on the next edge; ticks received in the transition cycle SHALL be ignored.
REQ-023 In RUN, pause==1 SHALL cause a move to PAUSE, with no decrement and no bonus applied on that edge.
REQ-024 In RUN with pause==0, sec_tick only SHALL set cnt = cnt-1.
REQ-025 In RUN with pause==0, bonus only SHALL set cnt = min(cnt+BONUS_SEC, 99).
REQ-026 In RUN with pause==0, sec_tick and bonus together SHALL set cnt = min(cnt+BONUS_SEC-1, 99).
REQ-027 In RUN, a decrement that produces cnt==0 SHALL move the FSM to DONE on the same edge.
REQ-028 A combined bonus and sec_tick at cnt==1 SHALL leave cnt=BONUS_SEC with no expiry, provided BONUS_SEC is at least 1.
REQ-029 In PAUSE, sec_tick and bonus SHALL be ignored and cnt held; pause==0 SHALL return the FSM to RUN on the next edge.
REQ-030 In DONE, cnt SHALL stay 0 and timeout SHALL be 1; bonus and ticks SHALL be ignored; exit SHALL occur only via state==0 or rst.
REQ-031 time_up SHALL be registered and high for exactly the first cycle spent in DONE.
REQ-032 running SHALL equal (FSM==RUN).
REQ-033 warning SHALL equal (FSM is RUN or PAUSE) and (cnt <= WARN_SEC) and (cnt != 0).
REQ-034 blink SHALL toggle on each half_tick while FSM==RUN and warning==1; it SHALL hold its value in PAUSE and be forced to 0 otherwise.
REQ-035 The arithmetic SHALL never wrap: cnt SHALL be at most 99, and no decrement SHALL occur below 0.

Reset
REQ-036 On rst==1 at an edge: FSM=IDLE, cnt=START_SEC, blink=0, time_up=0.
REQ-037 Out of reset, outputs SHALL read sec_tens/sec_ones=6/0 (defaults), running=0, warning=0, timeout=0.
REQ-038 rst asserted mid-RUN or mid-DONE SHALL behave identically to rst asserted from IDLE, with no time_up pulse.

Verification
REQ-039 Scenario: rst, then state=1, then 60 sec_tick pulses -> digits step 60,59,...,01,00; time_up high exactly 1 cycle on reaching 00; timeout=1; running=0.
REQ-040 Scenario: in RUN at cnt=30, pause=1, then 5 sec_tick pulses, then pause=0 -> cnt stays 30 throughout the pause; running=0 while paused; the next tick gives 29.
REQ-041 Scenario: cnt=97 with bonus, then cnt=3 with bonus and sec_tick in the same cycle -> the first gives 99 (saturated); the second gives 07, with the digits reading 0/7.
REQ-042 Scenario: count down to cnt=10 and issue 4 half_tick pulses -> warning=1 and blink toggles 1,0,1,0; at cnt=11, half_tick gives blink=0 and warning=0.
REQ-043 Scenario: cnt=1 with sec_tick and bonus together -> cnt=5, no time_up, still in RUN.
REQ-044 Scenario: in DONE, state=0 for 1 cycle, then state=1 -> IDLE with cnt=60, timeout=0, then RUN; separately, rst during RUN at cnt=20 -> cnt=60, IDLE.
